// File: rtl/pulse_seq_pkg.sv
// Shared types and register map for the pulse sequencer bank.
// Burst support is selected with PULSE_SEQ_BURST_EN.
package pulse_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INITIAL = 2'd1,
        HIGH    = 2'd2,
        LOW     = 2'd3
    } state_t;

    // Per-channel register offsets within the 4-byte channel window.
    localparam logic [1:0] OFF_INITIAL = 2'd0;
    localparam logic [1:0] OFF_LOW     = 2'd1;
    localparam logic [1:0] OFF_HIGH    = 2'd2;
    localparam logic [1:0] OFF_BURST   = 2'd3;

    localparam logic [7:0] ADDR_START = 8'hF0;
    localparam logic [7:0] ADDR_STOP  = 8'hF1;

    localparam int MAX_CHANNELS = 16;

endpackage

// File: rtl/pulse_seq_bank_if.sv
// Register-write strobe bus and per-channel status outputs of the pulse sequencer bank.
interface pulse_seq_bank_if #(
    parameter int N_CHANNELS  = 4,
    parameter int COUNT_WIDTH = 32
);
    logic                   reg_wr;
    logic [7:0]             reg_addr;
    logic [COUNT_WIDTH-1:0] reg_data;
    logic [N_CHANNELS-1:0]  laser_en;
    logic [N_CHANNELS-1:0]  running;
    logic [N_CHANNELS-1:0]  done;

    modport master (
        output reg_wr, reg_addr, reg_data,
        input  laser_en, running, done
    );

    modport slave (
        input  reg_wr, reg_addr, reg_data,
        output laser_en, running, done
    );
endinterface

// File: rtl/pulse_seq_channel.sv
// One sequencer channel: count registers, phase down-counter and phase FSM.
// With PULSE_SEQ_BURST_EN defined it also holds the burst register and pulse counter.
//
// state   | meaning
// IDLE    | channel stopped, outputs low
// INITIAL | start delay, laser off
// HIGH    | laser on
// LOW     | laser off between pulses
module pulse_seq_channel
    import pulse_seq_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr_initial,
    input  logic                   i_wr_low,
    input  logic                   i_wr_high,
    input  logic                   i_wr_burst,
    input  logic [COUNT_WIDTH-1:0] i_wr_data,
    input  logic                   i_start,
    input  logic                   i_stop,
    output logic                   o_laser_en,
    output logic                   o_running,
    output logic                   o_done
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] r_initial;
    logic [COUNT_WIDTH-1:0] r_low;
    logic [COUNT_WIDTH-1:0] r_high;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] w_cnt_nxt;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_laser_en;
    logic                   r_running;

    // A programmed count of 0 behaves as a one-cycle phase.
    function automatic logic [COUNT_WIDTH-1:0] phase_load(input logic [COUNT_WIDTH-1:0] count);
        return (count == '0) ? '0 : count - ONE;
    endfunction

`ifdef PULSE_SEQ_BURST_EN
    logic [COUNT_WIDTH-1:0] r_burst;
    logic [COUNT_WIDTH-1:0] r_pulses;
    logic [COUNT_WIDTH-1:0] w_pulses_nxt;
    logic                   w_last_pulse;
    logic                   w_done_nxt;
    logic                   r_done;

    assign w_last_pulse = (r_burst != '0) && ((r_pulses + ONE) == r_burst);
`else
    logic w_unused_burst;
    assign w_unused_burst = i_wr_burst;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
`ifdef PULSE_SEQ_BURST_EN
        w_pulses_nxt = r_pulses;
        w_done_nxt   = 1'b0;
`endif
        if (i_stop) begin
            w_state_nxt = IDLE;
        end else if (i_start) begin
            w_state_nxt = INITIAL;
            w_cnt_nxt   = phase_load(r_initial);
`ifdef PULSE_SEQ_BURST_EN
            w_pulses_nxt = '0;
`endif
        end else begin
            case (r_state)
                INITIAL, LOW: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = phase_load(r_high);
                    end else begin
                        w_cnt_nxt = r_cnt - ONE;
                    end
                end
                HIGH: begin
                    if (r_cnt == '0) begin
`ifdef PULSE_SEQ_BURST_EN
                        if (w_last_pulse) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = LOW;
                            w_cnt_nxt   = phase_load(r_low);
                            if (r_pulses != '1) begin
                                w_pulses_nxt = r_pulses + ONE;
                            end
                        end
`else
                        w_state_nxt = LOW;
                        w_cnt_nxt   = phase_load(r_low);
`endif
                    end else begin
                        w_cnt_nxt = r_cnt - ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Count registers only feed the next phase load, never the running counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_initial <= '0;
            r_low     <= '0;
            r_high    <= '0;
        end else begin
            if (i_wr_initial) r_initial <= i_wr_data;
            if (i_wr_low)     r_low     <= i_wr_data;
            if (i_wr_high)    r_high    <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_laser_en <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_laser_en <= (w_state_nxt == HIGH);
            r_running  <= (w_state_nxt != IDLE);
        end
    end

`ifdef PULSE_SEQ_BURST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst  <= '0;
            r_pulses <= '0;
            r_done   <= 1'b0;
        end else begin
            if (i_wr_burst) r_burst <= i_wr_data;
            r_pulses <= w_pulses_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_done = r_done;
`else
    assign o_done = 1'b0;
`endif

    assign o_laser_en = r_laser_en;
    assign o_running  = r_running;

endmodule

// File: rtl/pulse_seq_bank.sv
// Bank of independent laser pulse sequencers: address decode plus one channel instance each.
// Burst mode is compiled in when PULSE_SEQ_BURST_EN is defined.
module pulse_seq_bank
    import pulse_seq_pkg::*;
#(
    parameter int N_CHANNELS  = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    pulse_seq_bank_if.slave  bus
);

    logic [N_CHANNELS-1:0] w_laser_en;
    logic [N_CHANNELS-1:0] w_running;
    logic [N_CHANNELS-1:0] w_done;
    logic                  w_wr_start;
    logic                  w_wr_stop;

    assign w_wr_start = bus.reg_wr && (bus.reg_addr == ADDR_START);
    assign w_wr_stop  = bus.reg_wr && (bus.reg_addr == ADDR_STOP);

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        logic w_wr_chan;
        logic w_start;
        logic w_stop;

        // Channel windows sit at 4c..4c+3, so the upper six address bits select the channel.
        assign w_wr_chan = bus.reg_wr && (bus.reg_addr[7:2] == 6'(c));

        if (c < COUNT_WIDTH) begin : g_mask
            assign w_start = w_wr_start && bus.reg_data[c];
            assign w_stop  = w_wr_stop  && bus.reg_data[c];
        end else begin : g_nomask
            assign w_start = 1'b0;
            assign w_stop  = 1'b0;
        end

        pulse_seq_channel #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .i_wr_initial (w_wr_chan && (bus.reg_addr[1:0] == OFF_INITIAL)),
            .i_wr_low     (w_wr_chan && (bus.reg_addr[1:0] == OFF_LOW)),
            .i_wr_high    (w_wr_chan && (bus.reg_addr[1:0] == OFF_HIGH)),
            .i_wr_burst   (w_wr_chan && (bus.reg_addr[1:0] == OFF_BURST)),
            .i_wr_data    (bus.reg_data),
            .i_start      (w_start),
            .i_stop       (w_stop),
            .o_laser_en   (w_laser_en[c]),
            .o_running    (w_running[c]),
            .o_done       (w_done[c])
        );
    end

    assign bus.laser_en = w_laser_en;
    assign bus.running  = w_running;
    assign bus.done     = w_done;

endmodule

// File: tb/tb_pulse_seq_bank.sv
// Self-checking bench for pulse_seq_bank: directed scenarios plus random register traffic
// compared every cycle against a queue-based model of the per-channel output waveform.
module tb_pulse_seq_bank;

    localparam int NCH = 4;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    pulse_seq_bank_if #(.N_CHANNELS(NCH), .COUNT_WIDTH(CW)) bus ();

    pulse_seq_bank #(.N_CHANNELS(NCH), .COUNT_WIDTH(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: each running channel holds a queue of the laser_en values it will show on coming cycles;
    // when the queue drains, the next phase is appended from the count registers at that moment.
    int unsigned cfg_init  [NCH];
    int unsigned cfg_low   [NCH];
    int unsigned cfg_high  [NCH];
    int unsigned cfg_burst [NCH];
    bit          m_active  [NCH];
    bit          m_in_high [NCH];
    int unsigned m_pulses  [NCH];
    bit          mq        [NCH][$];
    logic [NCH-1:0] exp_laser, exp_running, exp_done;

    function automatic void push_phase(int c, bit val, int unsigned cnt);
        int unsigned n = (cnt == 0) ? 1 : cnt;
        for (int i = 0; i < int'(n); i++) mq[c].push_back(val);
    endfunction

    function automatic void model_edge(bit rst, bit wr, logic [7:0] addr, logic [31:0] data);
        exp_done = '0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                cfg_init[c] = 0; cfg_low[c] = 0; cfg_high[c] = 0; cfg_burst[c] = 0;
                m_active[c] = 0; m_in_high[c] = 0; m_pulses[c] = 0;
                mq[c].delete();
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr && addr == 8'hF1 && data[c]) begin
                    m_active[c] = 0;
                    mq[c].delete();
                end else if (wr && addr == 8'hF0 && data[c]) begin
                    m_active[c]  = 1;
                    m_in_high[c] = 0;
                    m_pulses[c]  = 0;
                    mq[c].delete();
                    push_phase(c, 1'b0, cfg_init[c]);
                end else if (m_active[c]) begin
                    mq[c].delete(0);
                    if (mq[c].size() == 0) begin
                        if (m_in_high[c]) begin
                            bit stop_now = 0;
                            m_pulses[c]++;
`ifdef PULSE_SEQ_BURST_EN
                            stop_now = (cfg_burst[c] != 0) && (m_pulses[c] == cfg_burst[c]);
`endif
                            if (stop_now) begin
                                m_active[c] = 0;
                                exp_done[c] = 1'b1;
                            end else begin
                                push_phase(c, 1'b0, cfg_low[c]);
                                m_in_high[c] = 0;
                            end
                        end else begin
                            push_phase(c, 1'b1, cfg_high[c]);
                            m_in_high[c] = 1;
                        end
                    end
                end
            end
            if (wr && addr < 8'(4 * NCH)) begin
                case (addr[1:0])
                    2'd0: cfg_init[addr[7:2]] = data;
                    2'd1: cfg_low[addr[7:2]]  = data;
                    2'd2: cfg_high[addr[7:2]] = data;
                    default: begin
`ifdef PULSE_SEQ_BURST_EN
                        cfg_burst[addr[7:2]] = data;
`endif
                    end
                endcase
            end
        end
        for (int c = 0; c < NCH; c++) begin
            exp_running[c] = m_active[c];
            exp_laser[c]   = m_active[c] && (mq[c].size() > 0) && mq[c][0];
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input bit rst, input bit wr, input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        reset      = rst;
        bus.reg_wr = wr;
        bus.reg_addr = addr;
        bus.reg_data = data;
        @(posedge clk);
        model_edge(rst, wr, addr, data);
        #1;
        check("laser_en", 32'(bus.laser_en), 32'(exp_laser));
        check("running",  32'(bus.running),  32'(exp_running));
        check("done",     32'(bus.done),     32'(exp_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 32'h0);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        step(0, 1, addr, data);
    endtask

    initial begin
        bit found;
        bit prev;
        int edges;
        int dones;

        reset = 1'b1;
        bus.reg_wr = 1'b0;
        bus.reg_addr = '0;
        bus.reg_data = '0;

        // Reset state
        step(1, 0, 8'h00, 32'h0);
        step(1, 1, 8'hF0, 32'hF);
        check("reset_outputs", {bus.laser_en, bus.running, bus.done}, 32'h0);

        // ch0 basic timing: 0x40 delay, 16 high, 32 low
        wr(8'h00, 32'h40);
        wr(8'h01, 32'h20);
        wr(8'h02, 32'h10);
        wr(8'hF0, 32'h01);
        check("ch0_running_after_start", 32'(bus.running[0]), 32'h1);
        idle(63);
        check("ch0_low_before_delay", 32'(bus.laser_en[0]), 32'h0);
        idle(1);
        check("ch0_high_at_delay", 32'(bus.laser_en[0]), 32'h1);
        idle(100);

        // Mid-HIGH rewrite of the high count only affects the next HIGH
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (exp_laser[0] && mq[0].size() > 8) found = 1;
            else idle(1);
        end
        check("wait_mid_high", 32'(found), 32'h1);
        wr(8'h02, 32'h08);
        idle(120);

        // ch1 all counts zero: toggles every cycle after a one-cycle initial phase
        wr(8'hF0, 32'h02);
        check("ch1_initial_low", 32'(bus.laser_en[1]), 32'h0);
        prev = bus.laser_en[1];
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("ch1_toggle", 32'(bus.laser_en[1]), 32'(!prev));
            prev = bus.laser_en[1];
        end

        // Start ch0+ch1, then stop ch0 only
        wr(8'hF0, 32'h03);
        idle(5);
        wr(8'hF1, 32'h01);
        check("ch0_stopped", {30'h0, bus.running[0], bus.laser_en[0]}, 32'h0);
        check("ch1_unaffected", 32'(bus.running[1]), 32'h1);
        check("stop_no_done", 32'(bus.done), 32'h0);
        idle(10);

        // Burst on ch2: 3 pulses of 4 high / 4 low
        wr(8'hF1, 32'h0F);
        wr(8'h09, 32'h04);
        wr(8'h0A, 32'h04);
        wr(8'h0B, 32'h03);
        wr(8'hF0, 32'h04);
        edges = 0;
        dones = 0;
        prev  = bus.laser_en[2];
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (bus.laser_en[2] && !prev) edges++;
            if (bus.done[2]) begin
                dones++;
                check("done_with_running_fall", 32'(bus.running[2]), 32'h0);
            end
            prev = bus.laser_en[2];
        end
`ifdef PULSE_SEQ_BURST_EN
        check("burst_pulses", 32'(edges), 32'd3);
        check("burst_done_count", 32'(dones), 32'd1);
`else
        check("freerun_pulses", 32'(edges > 3), 32'h1);
        check("freerun_no_done", 32'(dones), 32'd0);
`endif

        // Reset during ch0 HIGH, then restart without reprogramming
        wr(8'hF1, 32'h0F);
        wr(8'h00, 32'h02);
        wr(8'h01, 32'h05);
        wr(8'h02, 32'h05);
        wr(8'hF0, 32'h01);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (exp_laser[0]) found = 1;
            else idle(1);
        end
        check("wait_ch0_high", 32'(found), 32'h1);
        idle(2);
        step(1, 1, 8'hF0, 32'h0F);
        check("reset_mid_seq", {bus.laser_en, bus.running, bus.done}, 32'h0);
        wr(8'hF0, 32'h01);
        idle(6);

        // Random register traffic
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 199));
            if (r < 1)        step(1, 0, 8'h00, 32'h0);
            else if (r < 40)  wr(8'($urandom_range(0, 15)), 32'($urandom_range(0, 5)));
            else if (r < 48)  wr(8'hF0, $urandom);
            else if (r < 52)  wr(8'hF1, $urandom);
            else if (r < 56)  wr(8'($urandom_range(16, 239)), $urandom);
            else              idle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
